uart_tx: RTL and testbench

//  - Byte-stream to UART serial transmitter. Transmit-side counterpart to the uart_rx block.
//  - Accepts bytes on a valid/ready interface into an internal register FIFO.
//  - Serialises each byte as 8N1 (optional parity) on bit_out, LSB first.
//  - Sits between the debug command/response logic and the board UART TXD pin.

---
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte stream handshake into uart_tx: the producer drives data/valid and the transmitter returns ready.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1/8N2 serialiser, LSB first, TXD idles high.
// Define UART_TX_PARITY_EN to send an even parity bit after data bit 7.
module uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave byte_in,
    output logic     bit_out,
    output logic     busy
);
    localparam int unsigned TicksPerBit = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned PtrW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TickW       = (TicksPerBit > 1) ? $clog2(TicksPerBit) : 1;

    if (TicksPerBit < 2) begin : gen_bad_ticks
        $fatal(1, "uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
        $fatal(1, "uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             bit_out_q, bit_out_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            push, pop, fifo_empty, tick_end;
    logic [7:0]      head;

    // ready comes from the registered count only, so a same-cycle pop never frees a slot early
    assign fifo_empty    = (count_q == '0);
    assign byte_in.ready = (count_q != (PtrW + 1)'(FIFO_DEPTH));
    assign push          = byte_in.valid && byte_in.ready;
    assign head          = mem_q[rd_ptr_q];
    assign tick_end      = (tick_q == TickW'(TicksPerBit - 1));
    assign bit_out       = bit_out_q;
    assign busy          = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= byte_in.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_end ? '0 : tick_q + TickW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bit_out_d = bit_out_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                tick_d    = '0;
                bit_out_d = 1'b1;
                pop       = !fifo_empty;
            end
            StStart: begin
                if (tick_end) begin
                    bit_out_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        bit_out_d = parity_q;
                        state_d   = StParity;
`else
                        bit_out_d = 1'b1;
                        bit_idx_d = '0;
                        state_d   = StStop;
`endif
                    end else begin
                        bit_out_d = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick_end) begin
                    bit_out_d = 1'b1;
                    bit_idx_d = '0;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                // bit_idx counts stop bits here
                if (tick_end) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        pop     = !fifo_empty;
                        state_d = StIdle;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A pop always launches a start bit on the next cycle, whether from idle or from stop
        if (pop) begin
            shift_d   = head;
            bit_out_d = 1'b0;
            tick_d    = '0;
            state_d   = StStart;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            bit_out_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            bit_out_q <= bit_out_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits, 4-deep FIFO) checked every cycle against a
// frame-timeline model, plus directed literal checks on timing, ordering, reset and parity.
module tb_uart_tx;
    localparam int T     = 16;
    localparam int Depth = 4;
`ifdef UART_TX_PARITY_EN
    localparam int ParBits  = 1;
    localparam int FrameLen = 176;
`else
    localparam int ParBits  = 0;
    localparam int FrameLen = 160;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       va  = 1'b0;
    logic       vb  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       bit_a, busy_a, bit_b, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    uart_tx_if ia ();
    uart_tx_if ib ();
    assign ia.data  = din;
    assign ia.valid = va;
    assign ib.data  = din;
    assign ib.valid = vb;

    uart_tx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .FIFO_DEPTH(Depth), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .byte_in(ia), .bit_out(bit_a), .busy(busy_a)
    );
    uart_tx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .FIFO_DEPTH(Depth), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .byte_in(ib), .bit_out(bit_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic line(input int d);
        return (d == 0) ? bit_a : bit_b;
    endfunction

    // Model: FIFO as an array, each frame as (byte, start cycle); line value is a frame-bit lookup.
    logic [7:0] m_q   [2][Depth];
    int         m_cnt [2];
    logic       m_act [2];
    int         m_t0  [2];
    logic [7:0] m_cur [2];
    logic       m_bit [2];
    logic       m_busy[2];
    logic       m_rdy [2];
    logic       m_live = 1'b0;

    function automatic int flen(input int d);
        return (9 + ((d == 0) ? 1 : 2) + ParBits) * T;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (ParBits == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic model_step(input int d);
        int   pre;
        logic acc;
        if (rst) begin
            m_cnt[d] = 0;
            m_act[d] = 1'b0;
        end else begin
            pre = m_cnt[d];
            acc = ((d == 0) ? va : vb) && (pre < Depth);
            if (m_act[d] && (cyc - m_t0[d]) == flen(d)) m_act[d] = 1'b0;
            if (!m_act[d] && pre > 0) begin
                m_cur[d] = m_q[d][0];
                for (int i = 0; i < Depth - 1; i++) m_q[d][i] = m_q[d][i+1];
                m_cnt[d]--;
                m_act[d] = 1'b1;
                m_t0[d]  = cyc;
            end
            if (acc) begin
                m_q[d][m_cnt[d]] = din;
                m_cnt[d]++;
            end
        end
        m_bit[d]  = m_act[d] ? frame_bit(m_cur[d], (cyc - m_t0[d]) / T) : 1'b1;
        m_busy[d] = m_act[d] || (m_cnt[d] != 0);
        m_rdy[d]  = (m_cnt[d] < Depth);
    endtask

    initial begin : model
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            m_act[d] = 1'b0;
            m_t0[d]  = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) model_step(d);
            m_live = 1'b1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("bit_out_a", bit_a, m_bit[0]);
                check("busy_a", busy_a, m_busy[0]);
                check("ready_a", ia.ready, m_rdy[0]);
                check("bit_out_b", bit_b, m_bit[1]);
                check("busy_b", busy_b, m_busy[1]);
                check("ready_b", ib.ready, m_rdy[1]);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [7:0] b, output int pc);
        din = b;
        if (d == 0) va = 1'b1; else vb = 1'b1;
        step;
        pc = cyc;
        va = 1'b0;
        vb = 1'b0;
    endtask

    // Decode one frame by mid-bit sampling; fall is the cycle the start bit first appears.
    task automatic capture(input int d, output logic [7:0] b, output logic par, output int fall);
        int n = 0;
        while (line(d) !== 1'b0 && n < 1000) begin
            step;
            n++;
        end
        check("start_seen", n < 1000, 1);
        fall = cyc;
        repeat (T / 2) step;
        check("start_bit", line(d), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (T) step;
            b[i] = line(d);
        end
        par = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (T) step;
        par = line(d);
`endif
        repeat (T) step;
        check("stop_bit", line(d), 1);
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((busy_a || busy_b) && n < 3000) begin
            step;
            n++;
        end
        check("idle_reached", n < 3000, 1);
    endtask

    initial begin : stim
        logic [7:0] b1, b2;
        logic       p1, p2, r;
        int         f1, f2, pc, n, lows, pct, first_low, acc, acc6, guard;
        logic [7:0] got   [6];
        int         falls [6];

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_bit_out", bit_a, 1);
        check("reset_busy", busy_a, 0);
        check("reset_ready", ia.ready, 1);
        step;

        // Single byte
        push(0, 8'h55, pc);
        capture(0, b1, p1, f1);
        check("single_fall_latency", f1 - pc, 1);
        check("single_byte", b1, 8'h55);
        n = 0;
        while (busy_a && n < 1000) begin
            step;
            n++;
        end
        check("single_frame_len", cyc - f1, FrameLen);

        // Back-to-back
        va  = 1'b1;
        din = 8'hA3;
        step;
        din = 8'h0F;
        step;
        va = 1'b0;
        capture(0, b1, p1, f1);
        capture(0, b2, p2, f2);
        check("b2b_first", b1, 8'hA3);
        check("b2b_second", b2, 8'h0F);
        check("b2b_no_gap", f2 - f1, FrameLen);
        wait_idle;

        // FIFO full: hold valid over 6 bytes
        first_low = -1;
        acc       = 0;
        acc6      = 0;
        guard     = 0;
        fork
            begin
                va  = 1'b1;
                din = 8'h01;
                while (acc < 6 && guard < 3000) begin
                    r = ia.ready;
                    step;
                    guard++;
                    if (r) begin
                        acc++;
                        if (acc == 6) acc6 = cyc;
                        din = 8'(acc + 1);
                    end
                    if (!ia.ready && first_low < 0) first_low = acc;
                end
                va = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) capture(0, got[k], p1, falls[k]);
            end
        join
        check("full_accepts_before_stall", first_low, 5);
        check("full_ready_after_pop", acc6 - falls[1], 1);
        for (int k = 0; k < 6; k++) check("full_order", got[k], k + 1);
        wait_idle;

        // Reset during data bit 3 of 0xFF with two bytes queued
        va  = 1'b1;
        din = 8'hFF;
        step;
        pc  = cyc;
        din = 8'h01;
        step;
        din = 8'h02;
        step;
        va = 1'b0;
        f1 = pc + 1;
        while (cyc < f1 + 4 * T + T / 2) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("midrst_bit_out", bit_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_ready", ia.ready, 1);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            step;
            if (bit_a !== 1'b1) lows++;
            if (busy_a !== 1'b0) lows++;
        end
        check("midrst_quiet", lows, 0);

        // Two stop bits
        push(1, 8'h00, pc);
        step;
        f1 = pc + 1;
        check("stop2_start", bit_b, 0);
        while (cyc < f1 + (9 + ParBits) * T - 1) step;
        check("stop2_last_bit", bit_b, 0);
        n = 0;
        step;
        while (busy_b && bit_b === 1'b1 && n < 100) begin
            n++;
            step;
        end
        check("stop2_high_len", n, 32);
        check("stop2_idle_line", bit_b, 1);

`ifdef UART_TX_PARITY_EN
        va  = 1'b1;
        din = 8'h07;
        step;
        din = 8'h55;
        step;
        va = 1'b0;
        capture(0, b1, p1, f1);
        capture(0, b2, p2, f2);
        check("par_byte1", b1, 8'h07);
        check("par_bit1", p1, 1);
        check("par_byte2", b2, 8'h55);
        check("par_bit2", p2, 0);
        check("par_frame_len", f2 - f1, 176);
        wait_idle;
`endif

        // Randomised traffic with bursts of varying density and rare resets
        for (int blk = 0; blk < 8; blk++) begin
            pct = $urandom_range(0, 60);
            for (int i = 0; i < 500; i++) begin
                va  = ($urandom_range(0, 99) < pct);
                vb  = ($urandom_range(0, 99) < pct);
                din = 8'($urandom);
                rst = ($urandom_range(0, 599) == 0);
                step;
            end
        end
        va  = 1'b0;
        vb  = 1'b0;
        rst = 1'b0;
        wait_idle;
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
